// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
// Optional zero/negative result flags are built when LOGIC_FLAGS_EN is defined.
module logic_unit_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
`ifdef LOGIC_FLAGS_EN
  ,
  output logic             zr_o,
  output logic             ng_o
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s1_result;
  logic             s2_take;
  logic             s1_take;
  logic             in_ready;

  always_comb begin
    s1_result = a_q;
    case (op_q)
      3'b000:  s1_result = a_q & b_q;
      3'b001:  s1_result = a_q | b_q;
      3'b010:  s1_result = a_q ^ b_q;
      3'b011:  s1_result = ~(a_q & b_q);
      3'b100:  s1_result = ~(a_q | b_q);
      3'b101:  s1_result = ~(a_q ^ b_q);
      3'b110:  s1_result = ~a_q;
      default: s1_result = a_q;
    endcase
  end

  // S1 may refill in the same cycle its beat moves on, so in_ready never looks at in_valid_i.
  always_comb begin
    s2_take     = s1_valid_q && (!out_valid_q || out_ready_i);
    in_ready    = !s1_valid_q || s2_take;
    s1_take     = in_valid_i && in_ready;

    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    if (s1_take) begin
      s1_valid_d = 1'b1;
      a_d        = a_i;
      b_d        = b_i;
      op_d       = op_i;
    end else if (s2_take) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (s2_take) begin
      out_valid_d = 1'b1;
      out_d       = s1_result;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 3'b000;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;

`ifdef LOGIC_FLAGS_EN
  logic zr_q, zr_d;
  logic ng_q, ng_d;

  // Flags travel with the result so they hold under backpressure exactly like out_o.
  always_comb begin
    zr_d = zr_q;
    ng_d = ng_q;
    if (s2_take) begin
      zr_d = (s1_result == {WIDTH{1'b0}});
      ng_d = s1_result[WIDTH-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      zr_q <= 1'b0;
      ng_q <= 1'b0;
    end else begin
      zr_q <= zr_d;
      ng_q <= ng_d;
    end
  end

  assign zr_o = zr_q;
  assign ng_o = ng_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed cases plus a randomized run
// against a queue-based reference; flag checks are compiled in with LOGIC_FLAGS_EN.
module tb_logic_unit_pipe;

  localparam int W = 16;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic [2:0]   op_i = 3'b000;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [W-1:0] out_o;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
`ifdef LOGIC_FLAGS_EN
  logic         zr_o;
  logic         ng_o;
`endif

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_i        (op_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_o       (out_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
`ifdef LOGIC_FLAGS_EN
    ,
    .zr_o        (zr_o),
    .ng_o        (ng_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the op table applied to whole words.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    logic [W-1:0] ones;
    ones = '1;
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ones ^ (a & b);
      3'd4:    return ones ^ (a | b);
      3'd5:    return ones ^ (a ^ b);
      3'd6:    return ones ^ a;
      default: return a;
    endcase
  endfunction

  logic [W-1:0] exp_q[$];
  int           push_cnt = 0;
  int           pop_cnt  = 0;
  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_val = '0;

  // Monitor on the falling edge: inputs and outputs are settled for the coming rising edge.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", 32'(out_valid_o), 32'd1);
        chk("hold_data", 32'(out_o), 32'(hold_val));
      end
      hold_pending = out_valid_o && !out_ready_i;
      hold_val     = out_o;
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back(ref_op(a_i, b_i, op_i));
        push_cnt++;
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_beat", 32'd1, 32'd0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("sb_data", 32'(out_o), 32'(e));
`ifdef LOGIC_FLAGS_EN
          chk("sb_zr", 32'(zr_o), 32'(e == '0));
          chk("sb_ng", 32'(ng_o), 32'(e[W-1]));
`endif
          pop_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One isolated beat: result appears after the edge following the accept edge.
  task automatic one_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic [W-1:0] exp);
    a_i = a; b_i = b; op_i = op; in_valid_i = 1'b1; out_ready_i = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0;
    a_i = ~a; b_i = ~b; op_i = ~op;
    chk({tag, "_lat"}, 32'(out_valid_o), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(out_valid_o), 32'd1);
    chk({tag, "_out"}, 32'(out_o), 32'(exp));
    $display("beat %s: a=%h b=%h op=%0d out=%h", tag, a, b, op, out_o);
  endtask

  logic [W-1:0] sa[8];
  logic [W-1:0] sb[8];
  logic [2:0]   sop[8];

  initial begin
    // Reset state
    #2;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out", 32'(out_o), 32'd0);
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    tick();
    rst_n_i = 1'b1;
    tick();

    // Directed ops
    one_beat("and", 16'hAAAA, 16'h3BF1, 3'd0, 16'h2AA0);
    one_beat("or",  16'hAAAA, 16'h3BF1, 3'd1, 16'hBBFB);
    one_beat("xor", 16'hAAAA, 16'h3BF1, 3'd2, 16'h915B);
    one_beat("nand", 16'hFFFF, 16'h0000, 3'd3, 16'hFFFF);
    one_beat("nor",  16'hFFFF, 16'h0000, 3'd4, 16'h0000);
`ifdef LOGIC_FLAGS_EN
    chk("nor_zr", 32'(zr_o), 32'd1);
    chk("nor_ng", 32'(ng_o), 32'd0);
`endif
    one_beat("not",  16'hFFFF, 16'h0000, 3'd6, 16'h0000);
    one_beat("pass", 16'hFFFF, 16'h0000, 3'd7, 16'hFFFF);
`ifdef LOGIC_FLAGS_EN
    chk("pass_zr", 32'(zr_o), 32'd0);
    chk("pass_ng", 32'(ng_o), 32'd1);
`endif
    one_beat("xnor", 16'h1234, 16'h1234, 3'd5, 16'hFFFF);

    // Streaming: 8 back-to-back beats, one result per cycle
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom); sb[i] = 16'($urandom); sop[i] = 3'($urandom_range(0, 7));
    end
    out_ready_i = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        a_i = sa[i]; b_i = sb[i]; op_i = sop[i]; in_valid_i = 1'b1;
        chk("stream_rdy", 32'(in_ready_o), 32'd1);
      end else begin
        in_valid_i = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk("stream_vld", 32'(out_valid_o), 32'd1);
        chk("stream_out", 32'(out_o), 32'(ref_op(sa[i-1], sb[i-1], sop[i-1])));
        $display("stream beat %0d: out=%h", i - 1, out_o);
      end
    end
    tick();
    chk("stream_idle", 32'(out_valid_o), 32'd0);

    // Backpressure: 3 beats offered with out_ready_i low for 5 cycles
    begin
      int idx = 0;
      int pop0;
      pop0 = pop_cnt;
      out_ready_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
        logic took;
        a_i = sa[idx]; b_i = sb[idx]; op_i = sop[idx]; in_valid_i = 1'b1;
        took = in_ready_o;
        tick();
        if (took) idx++;
      end
      chk("bp_accepted", 32'(idx), 32'd2);
      chk("bp_ready_low", 32'(in_ready_o), 32'd0);
      chk("bp_out_held", 32'(out_o), 32'(ref_op(sa[0], sb[0], sop[0])));
      out_ready_i = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(in_ready_o), 32'd1);
      tick();
      in_valid_i = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      chk("bp_drained", 32'(pop_cnt - pop0), 32'd3);
      $display("backpressure: accepted=%0d drained=%0d", idx, pop_cnt - pop0);
    end

    // Reset in the middle of a stream drops everything in flight
    out_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      a_i = 16'($urandom); b_i = 16'($urandom); op_i = 3'($urandom_range(0, 7));
      in_valid_i = 1'b1;
      tick();
    end
    #2 rst_n_i = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_out", 32'(out_o), 32'd0);
    in_valid_i = 1'b0;
    tick();
    #3 rst_n_i = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(in_ready_o), 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("mid_rst_no_stale", 32'(out_valid_o), 32'd0);
    end
    $display("mid-stream reset: pipeline empty after release");

    // Randomized traffic against the scoreboard
    begin
      int start;
      int cyc = 0;
      start = push_cnt;
      while ((push_cnt - start) < 10000 && cyc < 60000) begin
        in_valid_i  = ($urandom_range(0, 3) != 0);
        out_ready_i = ($urandom_range(0, 3) != 0);
        a_i  = 16'($urandom);
        b_i  = 16'($urandom);
        op_i = 3'($urandom_range(0, 7));
        tick();
        cyc++;
      end
      chk("rand_budget", 32'(cyc < 60000), 32'd1);
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      chk("rand_drain_empty", 32'(exp_q.size()), 32'd0);
      $display("random: beats=%0d cycles=%0d", push_cnt - start, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
